// File: rtl/cond_logic_banked.sv
// ============================================================================
// Module      : cond_logic_banked
// Description : ARM-style condition unit with banked NZCV flags, save/restore
//               copies and saturating executed/squashed event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_logic_banked #(
    parameter int NBANK = 2,
    parameter int CNTW  = 16,
    parameter int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Valid,
    input  logic            PCS,
    input  logic            RegW,
    input  logic            NoWrite,
    input  logic            MemW,
    input  logic [1:0]      FlagW,
    input  logic [3:0]      Cond,
    input  logic [3:0]      ALUFlags,
    input  logic [BW-1:0]   Bank,
    input  logic            SaveFlags,
    input  logic            RestoreFlags,
    input  logic            CntClr,
    output logic            PCSrc,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic            CondEx,
    output logic [3:0]      Flags,
    output logic [CNTW-1:0] ExecCount,
    output logic [CNTW-1:0] SquashCount
);

    localparam logic [BW:0]     c_NBANK   = (BW + 1)'(NBANK);
    localparam logic [CNTW-1:0] c_CNT_MAX = '1;

    logic [1:0]      r_nz    [NBANK];
    logic [1:0]      r_cv    [NBANK];
    logic [3:0]      r_saved [NBANK];
    logic [CNTW-1:0] r_exec;
    logic [CNTW-1:0] r_squash;

    logic       w_legal;
    logic       w_act;
    logic [3:0] w_live;
    logic       w_n, w_z, w_c, w_v;
    logic       w_pass;
    logic       w_cond_ex;

    assign w_legal = ({1'b0, Bank} < c_NBANK);
    assign w_act   = Valid & w_legal;

    // An illegal bank reads as all-zero flags.
    always_comb begin
        w_live = 4'b0000;
        for (int i = 0; i < NBANK; i++) begin
            if (w_legal && (Bank == BW'(i))) begin
                w_live = {r_nz[i], r_cv[i]};
            end
        end
    end

    assign {w_n, w_z, w_c, w_v} = w_live;

    always_comb begin
        w_pass = 1'b0;
        case (Cond)
            4'b0000: w_pass = w_z;
            4'b0001: w_pass = ~w_z;
            4'b0010: w_pass = w_c;
            4'b0011: w_pass = ~w_c;
            4'b0100: w_pass = w_n;
            4'b0101: w_pass = ~w_n;
            4'b0110: w_pass = w_v;
            4'b0111: w_pass = ~w_v;
            4'b1000: w_pass = w_c & ~w_z;
            4'b1001: w_pass = ~w_c | w_z;
            4'b1010: w_pass = (w_n == w_v);
            4'b1011: w_pass = (w_n != w_v);
            4'b1100: w_pass = ~w_z & (w_n == w_v);
            4'b1101: w_pass = w_z | (w_n != w_v);
            4'b1110: w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    assign w_cond_ex = w_act & w_pass;

    assign CondEx      = w_cond_ex;
    assign PCSrc       = PCS & w_cond_ex;
    assign RegWrite    = RegW & ~NoWrite & w_cond_ex;
    assign MemWrite    = MemW & w_cond_ex;
    assign Flags       = w_live;
    assign ExecCount   = r_exec;
    assign SquashCount = r_squash;

    // Restore overrides the ALU write; save always captures the pre-edge live
    // value, so save+restore together performs a swap.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NBANK; i++) begin
                r_nz[i]    <= 2'b00;
                r_cv[i]    <= 2'b00;
                r_saved[i] <= 4'b0000;
            end
        end else begin
            for (int i = 0; i < NBANK; i++) begin
                if (w_act && (Bank == BW'(i))) begin
                    if (RestoreFlags) begin
                        r_nz[i] <= r_saved[i][3:2];
                        r_cv[i] <= r_saved[i][1:0];
                    end else if (w_cond_ex) begin
                        if (FlagW[1]) r_nz[i] <= ALUFlags[3:2];
                        if (FlagW[0]) r_cv[i] <= ALUFlags[1:0];
                    end
                    if (SaveFlags) begin
                        r_saved[i] <= {r_nz[i], r_cv[i]};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || CntClr) begin
            r_exec   <= '0;
            r_squash <= '0;
        end else if (Valid) begin
            if (w_cond_ex) begin
                if (r_exec != c_CNT_MAX) r_exec <= r_exec + CNTW'(1);
            end else begin
                if (r_squash != c_CNT_MAX) r_squash <= r_squash + CNTW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cond_logic_banked.sv
// ============================================================================
// Module      : tb_cond_logic_banked
// Description : Scoreboard bench for cond_logic_banked (NBANK=3, CNTW=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_logic_banked;

    localparam int NB   = 3;
    localparam int CMAX = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Valid = 1'b0, PCS = 1'b0, RegW = 1'b0, NoWrite = 1'b0, MemW = 1'b0;
    logic [1:0] FlagW = 2'b00;
    logic [3:0] Cond = 4'b0000, ALUFlags = 4'b0000;
    logic [1:0] Bank = 2'b00;
    logic       SaveFlags = 1'b0, RestoreFlags = 1'b0, CntClr = 1'b0;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags, ExecCount, SquashCount;

    cond_logic_banked #(.NBANK(NB), .CNTW(4)) dut (
        .clk(clk), .reset(reset), .Valid(Valid), .PCS(PCS), .RegW(RegW),
        .NoWrite(NoWrite), .MemW(MemW), .FlagW(FlagW), .Cond(Cond),
        .ALUFlags(ALUFlags), .Bank(Bank), .SaveFlags(SaveFlags),
        .RestoreFlags(RestoreFlags), .CntClr(CntClr), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
        .Flags(Flags), .ExecCount(ExecCount), .SquashCount(SquashCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       cex, pcsrc, regw, memw;
        logic [3:0] flags, ec, sc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference state: whole 4-bit flag words per bank, integer counters.
    logic [3:0] m_live  [NB];
    logic [3:0] m_saved [NB];
    int         m_exec, m_squash;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v;
        {n, z, cc, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cc;
            4'd3:  return !cc;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cc && !z;
            4'd9:  return !cc || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // One clock of stimulus: predict, enqueue, advance, update the model.
    task automatic cycle();
        exp_t       e;
        logic       legal, cex;
        logic [3:0] live, nl;
        int         b;
        b     = int'(Bank);
        legal = (b < NB);
        live  = legal ? m_live[b] : 4'b0000;
        cex   = Valid && legal && cond_ok(Cond, live);
        e.cex   = cex;
        e.pcsrc = PCS && cex;
        e.regw  = RegW && !NoWrite && cex;
        e.memw  = MemW && cex;
        e.flags = live;
        e.ec    = 4'(m_exec);
        e.sc    = 4'(m_squash);
        q.push_back(e);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NB; i++) begin
                m_live[i]  = 4'b0000;
                m_saved[i] = 4'b0000;
            end
            m_exec   = 0;
            m_squash = 0;
        end else begin
            if (Valid && legal) begin
                nl = live;
                if (cex && FlagW[1]) nl[3:2] = ALUFlags[3:2];
                if (cex && FlagW[0]) nl[1:0] = ALUFlags[1:0];
                if (RestoreFlags) nl = m_saved[b];
                if (SaveFlags) m_saved[b] = live;
                m_live[b] = nl;
            end
            if (CntClr) begin
                m_exec   = 0;
                m_squash = 0;
            end else if (Valid) begin
                if (cex) m_exec = (m_exec < CMAX) ? m_exec + 1 : CMAX;
                else     m_squash = (m_squash < CMAX) ? m_squash + 1 : CMAX;
            end
        end
        #1;
    endtask

    task automatic op(input logic v, input logic [3:0] c, input logic [1:0] fw,
                      input logic [3:0] alu, input logic [1:0] bk,
                      input logic sv, input logic rs, input logic clr);
        Valid = v; Cond = c; FlagW = fw; ALUFlags = alu; Bank = bk;
        SaveFlags = sv; RestoreFlags = rs; CntClr = clr;
        cycle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("CondEx",      {3'b0, CondEx},   {3'b0, e.cex});
                chk("PCSrc",       {3'b0, PCSrc},    {3'b0, e.pcsrc});
                chk("RegWrite",    {3'b0, RegWrite}, {3'b0, e.regw});
                chk("MemWrite",    {3'b0, MemWrite}, {3'b0, e.memw});
                chk("Flags",       Flags,            e.flags);
                chk("ExecCount",   ExecCount,        e.ec);
                chk("SquashCount", SquashCount,      e.sc);
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < NB; i++) begin
            m_live[i]  = 4'b0000;
            m_saved[i] = 4'b0000;
        end
        m_exec = 0;
        m_squash = 0;
        repeat (2) @(posedge clk);
        #1;
        PCS = 1'b1; RegW = 1'b1; NoWrite = 1'b0; MemW = 1'b1;
        // Checked reset cycles, including an active instruction that must be ignored.
        op(1'b0, 4'hE, 2'b00, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        op(1'b1, 4'hE, 2'b11, 4'hF, 2'd1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        // Fresh bank: EQ squashes, AL executes.
        op(1'b1, 4'h0, 2'b00, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        op(1'b1, 4'hE, 2'b00, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        // Flag write lands only in bank 1.
        op(1'b1, 4'hE, 2'b11, 4'h4, 2'd1, 1'b0, 1'b0, 1'b0);
        op(1'b1, 4'h0, 2'b00, 4'h0, 2'd1, 1'b0, 1'b0, 1'b0);
        op(1'b1, 4'h0, 2'b00, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        // Build live=1001, saved=0110 in bank 1, then swap.
        op(1'b1, 4'hE, 2'b11, 4'h6, 2'd1, 1'b0, 1'b0, 1'b0);
        op(1'b1, 4'hE, 2'b11, 4'h9, 2'd1, 1'b1, 1'b0, 1'b0);
        op(1'b1, 4'hF, 2'b00, 4'h0, 2'd1, 1'b1, 1'b1, 1'b0);
        op(1'b1, 4'hE, 2'b11, 4'hF, 2'd1, 1'b0, 1'b1, 1'b0);
        op(1'b1, 4'hF, 2'b00, 4'h0, 2'd1, 1'b0, 1'b0, 1'b0);
        // Never condition with all requests set.
        op(1'b1, 4'hF, 2'b11, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0);
        // Counter saturation then clear with a simultaneous executed instruction.
        repeat (20) op(1'b1, 4'hE, 2'b00, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        op(1'b1, 4'hE, 2'b00, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
        // Illegal bank must not touch any state.
        op(1'b1, 4'hE, 2'b11, 4'hF, 2'd3, 1'b1, 1'b1, 1'b0);
        op(1'b0, 4'hE, 2'b00, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        op(1'b0, 4'hE, 2'b00, 4'h0, 2'd1, 1'b0, 1'b0, 1'b0);
        op(1'b0, 4'hE, 2'b00, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0);
        // Randomized traffic with occasional mid-sequence reset.
        for (int k = 0; k < 600; k++) begin
            reset   = ($urandom_range(0, 39) == 0);
            PCS     = 1'($urandom);
            RegW    = 1'($urandom);
            NoWrite = 1'($urandom);
            MemW    = 1'($urandom);
            op(($urandom_range(0, 4) != 0), 4'($urandom), 2'($urandom), 4'($urandom),
               2'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 29) == 0));
        end
        reset = 1'b0;
        Valid = 1'b0;
        @(negedge clk);
        #1;
        chk("queue_drained", 4'(q.size()), 4'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cond_logic_banked.md
COND_LOGIC_BANKED -- requirements
Module: cond_logic_banked

Interface
REQ-001 Parameter NBANK, default 2, number of independent NZCV flag banks (1..8).
REQ-002 Parameter CNTW, default 16, width of the executed/squashed event counters.
REQ-003 Parameter BW, default $clog2(NBANK) (minimum 1), width of the bank select.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 Valid  input  1  an instruction is presented this cycle.
REQ-007 PCS, RegW, NoWrite, MemW  input  1 each  unconditional branch, register-write, compare-only and memory-write requests from decode.
REQ-008 FlagW  input  2  flag-write request: bit1 updates N,Z; bit0 updates C,V.
REQ-009 Cond  input  4  ARM condition field.
REQ-010 ALUFlags  input  4  {N,Z,C,V} produced by the ALU this cycle.
REQ-011 Bank  input  BW  flag bank used by this instruction.
REQ-012 SaveFlags, RestoreFlags  input  1 each  copy live flags to the bank's saved copy, or saved copy to live.
REQ-013 CntClr  input  1  clear both event counters.
REQ-014 PCSrc, RegWrite, MemWrite  output  1 each  gated write and branch enables.
REQ-015 CondEx  output  1  condition passed for the current instruction.
REQ-016 Flags  output  4  live {N,Z,C,V} of the selected Bank, registered value.
REQ-017 ExecCount, SquashCount  output  CNTW each  executed and squashed instruction counts.

Function
REQ-018 Each bank holds live NZ, live CV and a 4-bit saved copy; all are registers.
REQ-019 Condition evaluation uses the registered live flags of Bank, never this cycle's ALUFlags.
REQ-020 Cond decode: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
REQ-021 Bank >= NBANK is illegal: CondEx=0, Flags=0, no state in any bank changes.
REQ-022 CondEx = Valid & legal Bank & cond result; with Valid=0 CondEx=0.
REQ-023 PCSrc = PCS&CondEx; RegWrite = RegW&!NoWrite&CondEx; MemWrite = MemW&CondEx; all combinational, zero latency.
REQ-024 When CondEx=1, FlagW[1] loads ALUFlags[3:2] into the bank's live NZ and FlagW[0] loads ALUFlags[1:0] into its live CV at the next edge; other banks unchanged.
REQ-025 SaveFlags/RestoreFlags act only when Valid=1 and Bank legal, independent of CondEx.
REQ-026 Priority on live flags of the selected bank: reset > RestoreFlags > ALU flag write.
REQ-027 SaveFlags captures the pre-edge live value, so a same-cycle ALU flag write is not saved.
REQ-028 SaveFlags and RestoreFlags together swap live and saved values in one edge.
REQ-029 RestoreFlags with FlagW and CondEx=1: restored value wins for both NZ and CV.
REQ-030 ExecCount increments when Valid=1 and CondEx=1; SquashCount increments when Valid=1 and CondEx=0 (includes Cond=1111 and illegal Bank).
REQ-031 Counters saturate at 2^CNTW-1 and never wrap.
REQ-032 CntClr zeroes both counters; a same-cycle increment is discarded.
REQ-033 Flags reflects a write starting the cycle after the edge that performs it.

Reset
REQ-034 On reset all live and saved flags of every bank are 0000 and both counters are 0.
REQ-035 During reset cycles combinational outputs still follow REQ-019..023 from the zeroed state; no flag, save or counter updates occur.
REQ-036 Reset asserted mid-sequence discards any pending update at that edge; first update after reset is on the edge following deassertion.

Verification
REQ-037 Reset, Bank=0, Cond=0000, Valid=1 -> CondEx=0 (Z=0), SquashCount=1 next cycle; Cond=1110 -> CondEx=1, ExecCount increments.
REQ-038 Cond=1110, FlagW=11, ALUFlags=0100, Bank=1 -> bank1 Flags=0100 next cycle, bank0 still 0000; Cond=0000 on bank1 -> CondEx=1.
REQ-039 Bank1 live=1001, saved=0110, SaveFlags=RestoreFlags=1 -> live=0110, saved=1001 after one edge.
REQ-040 Cond=1111 with PCS=RegW=MemW=1 -> PCSrc=RegWrite=MemWrite=0, no flag change, SquashCount+1.
REQ-041 CNTW=4, 20 executed instructions -> ExecCount holds 15; CntClr with Valid and CondEx=1 -> 0.
REQ-042 NBANK=3, Bank=3 with FlagW=11 -> CondEx=0, Flags=0000, no bank modified.
